// File: rtl/snapshot_mem_ext.sv
// Bridges a narrow upstream bus onto a wide memory through a snapshot register of P bus-width partitions.
// Optional SNAPSHOT_MEM_TIMEOUT_EN adds a memory-access timeout of TIMEOUT_CYCLES cycles.
module snapshot_mem_ext #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 64,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int WR_TRIG_LAST   = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      soft_rst,
    input  logic                      req_vld,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [BUS_DATA_WIDTH-1:0] wr_data,
    output logic                      ack_vld,
    output logic                      err,
    output logic [BUS_DATA_WIDTH-1:0] rd_data,
    output logic                      mem_req_vld,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_ack_vld,
    input  logic                      mem_err,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int P   = MEM_DATA_WIDTH / BUS_DATA_WIDTH;
    localparam int RSV = $clog2(MEM_DATA_WIDTH / 8);
    localparam int BSV = $clog2(BUS_DATA_WIDTH / 8);
    localparam int KW  = (P > 1) ? $clog2(P) : 1;
    localparam logic [KW-1:0] T_IDX = (WR_TRIG_LAST != 0) ? KW'(P - 1) : KW'(0);
    localparam logic [BUS_ADDR_WIDTH-1:0] ALIGN_MASK =
        (BUS_ADDR_WIDTH'(1) << BSV) - BUS_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        MEM  = 3'b010,
        RSP  = 3'b100
    } state_t;

    state_t                    state_r;
    logic [MEM_DATA_WIDTH-1:0] snap_r;
    logic                      rsp_err_r;
    logic [BUS_DATA_WIDTH-1:0] rsp_data_r;

    logic [KW-1:0]             k_s;
    logic                      proto_err_s;
    logic [MEM_DATA_WIDTH-1:0] snap_wr_s;
    logic [BUS_DATA_WIDTH-1:0] snap_part_s;
    logic                      timeout_s;
    logic                      addr_unused_s;

    assign addr_unused_s = ^addr;
    assign k_s           = (P > 1) ? KW'(addr >> BSV) : KW'(0);
    assign proto_err_s   = ((addr & ALIGN_MASK) != '0) || (wr_en == rd_en);
    assign snap_part_s   = snap_r[k_s*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];

    // Snapshot image with the incoming write merged into partition k.
    always_comb begin
        snap_wr_s = snap_r;
        snap_wr_s[k_s*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = wr_data;
    end

`ifdef SNAPSHOT_MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] tmo_cnt_r;

    assign timeout_s = (state_r == MEM) && !mem_ack_vld &&
                       (tmo_cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Counts MEM cycles spent waiting for the memory acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (soft_rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == MEM) && !mem_ack_vld && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Main control: request decode, snapshot updates and memory request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_r      <= '0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            mem_req_vld <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else if (soft_rst) begin
            state_r     <= IDLE;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            mem_req_vld <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_vld) begin
                        if (proto_err_s) begin
                            state_r    <= RSP;
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= '0;
                        end else if (wr_en) begin
                            snap_r <= snap_wr_s;
                            if (k_s == T_IDX) begin
                                state_r     <= MEM;
                                mem_req_vld <= 1'b1;
                                mem_wr_en   <= 1'b1;
                                mem_addr    <= addr[RSV+MEM_ADDR_WIDTH-1:RSV];
                                mem_wr_data <= snap_wr_s;
                            end else begin
                                state_r    <= RSP;
                                rsp_err_r  <= 1'b0;
                                rsp_data_r <= '0;
                            end
                        end else begin
                            if (k_s == KW'(0)) begin
                                state_r     <= MEM;
                                mem_req_vld <= 1'b1;
                                mem_rd_en   <= 1'b1;
                                mem_addr    <= addr[RSV+MEM_ADDR_WIDTH-1:RSV];
                            end else begin
                                state_r    <= RSP;
                                rsp_err_r  <= 1'b0;
                                rsp_data_r <= snap_part_s;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEM: begin
                    if (mem_ack_vld || timeout_s) begin
                        if (mem_ack_vld && mem_rd_en && !mem_err) begin
                            snap_r <= mem_rd_data;
                        end else begin
                            snap_r <= snap_r;
                        end
                        state_r     <= IDLE;
                        mem_req_vld <= 1'b0;
                        mem_wr_en   <= 1'b0;
                        mem_rd_en   <= 1'b0;
                        mem_addr    <= '0;
                        mem_wr_data <= '0;
                    end else begin
                        state_r <= MEM;
                    end
                end
                RSP: begin
                    state_r    <= IDLE;
                    rsp_err_r  <= 1'b0;
                    rsp_data_r <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_req_vld <= 1'b0;
                    mem_wr_en   <= 1'b0;
                    mem_rd_en   <= 1'b0;
                    mem_addr    <= '0;
                    mem_wr_data <= '0;
                end
            endcase
        end
    end

    // Upstream response; the memory-ack path is combinational so the ack lands in the ack cycle.
    always_comb begin
        ack_vld = 1'b0;
        err     = 1'b0;
        rd_data = '0;
        if (soft_rst) begin
            ack_vld = 1'b0;
        end else if (state_r == RSP) begin
            ack_vld = 1'b1;
            err     = rsp_err_r;
            rd_data = rsp_data_r;
        end else if ((state_r == MEM) && mem_ack_vld) begin
            ack_vld = 1'b1;
            err     = mem_err;
            rd_data = mem_rd_en ? mem_rd_data[BUS_DATA_WIDTH-1:0] : '0;
        end else if (timeout_s) begin
            ack_vld = 1'b1;
            err     = 1'b1;
        end else begin
            ack_vld = 1'b0;
        end
    end

endmodule

// File: tb/tb_snapshot_mem_ext.sv
// Self-checking bench for snapshot_mem_ext: vector table plus hand-written sequences,
// upstream responses checked through a scoreboard queue.
module tb_snapshot_mem_ext;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n, soft_rst, req_vld, wr_en, rd_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic        ack_vld, err;
    logic [31:0] rd_data;
    logic        mem_req_vld, mem_wr_en, mem_rd_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_ack_vld, mem_err;
    logic [63:0] mem_rd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snapshot_mem_ext #(
        .BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(64), .MEM_DATA_WIDTH(64),
        .MEM_ADDR_WIDTH(32), .WR_TRIG_LAST(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .err(err), .rd_data(rd_data),
        .mem_req_vld(mem_req_vld), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_ack_vld(mem_ack_vld), .mem_err(mem_err), .mem_rd_data(mem_rd_data)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [63:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        merr;
        logic [63:0] mrdata;
        logic        exp_mem;
        logic [31:0] exp_maddr;
        logic [63:0] exp_mwdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [63:0] a,
                                input logic [31:0] wd, input int lat, input logic merr,
                                input logic [63:0] mrd, input logic emem, input logic [31:0] emaddr,
                                input logic [63:0] emwd, input logic eerr, input logic [31:0] erd);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.lat = lat; v.merr = merr;
        v.mrdata = mrd; v.exp_mem = emem; v.exp_maddr = emaddr; v.exp_mwdata = emwd;
        v.exp_err = eerr; v.exp_rdata = erd;
        return v;
    endfunction

    // Scoreboard: every upstream ack must match the oldest pending expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (ack_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack actual err=%0b rd_data=%h required no ack", err, rd_data);
                end else begin
                    e = sb.pop_front();
                    chk("ack_err", {63'd0, err}, {63'd0, e.err});
                    chk("ack_rd_data", {32'd0, rd_data}, {32'd0, e.data});
                end
            end else if (err !== 1'b0 || rd_data !== 32'd0) begin
                checks++;
                failures++;
                $display("FAIL idle_rsp actual err=%0b rd_data=%h required 0", err, rd_data);
            end
        end
    end

    task automatic drive_req(input logic wr, input logic rd, input logic [63:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_vld = 1'b1; wr_en = wr; rd_en = rd; addr = a; wr_data = wd;
        @(posedge clk); #1;
        req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic mem_respond(input logic merr, input logic [63:0] mrd);
        @(posedge clk); #1;
        mem_ack_vld = 1'b1; mem_err = merr; mem_rd_data = mrd;
        @(posedge clk); #1;
        mem_ack_vld = 1'b0; mem_err = 1'b0; mem_rd_data = 64'd0;
        @(negedge clk);
        chk("mem_req_drop", {63'd0, mem_req_vld}, 64'd0);
        chk("mem_wr_data_idle", mem_wr_data, 64'd0);
    endtask

    task automatic apply_vec(input vec_t v);
        sb.push_back('{err: v.exp_err, data: v.exp_rdata});
        drive_req(v.wr, v.rd, v.addr, v.wdata);
        @(negedge clk);
        if (!v.exp_mem) begin
            chk("no_mem_req", {63'd0, mem_req_vld}, 64'd0);
        end else begin
            chk("mem_req_vld", {63'd0, mem_req_vld}, 64'd1);
            chk("mem_wr_en", {63'd0, mem_wr_en}, {63'd0, v.wr});
            chk("mem_rd_en", {63'd0, mem_rd_en}, {63'd0, v.rd});
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.exp_maddr});
            if (v.wr) chk("mem_wr_data", mem_wr_data, v.exp_mwdata);
            for (int c = 0; c < v.lat; c++) begin
                @(negedge clk);
                chk("mem_hold_vld", {63'd0, mem_req_vld}, 64'd1);
                chk("mem_hold_addr", {32'd0, mem_addr}, {32'd0, v.exp_maddr});
                if (v.wr) chk("mem_hold_wdata", mem_wr_data, v.exp_mwdata);
            end
            mem_respond(v.merr, v.mrdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; soft_rst = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = 64'd0; wr_data = 32'd0; mem_ack_vld = 1'b0; mem_err = 1'b0; mem_rd_data = 64'd0;

        // vector table: wr, rd, addr, wdata, lat, merr, mrdata, exp_mem, exp_maddr, exp_mwdata, exp_err, exp_rdata
        vecs.push_back(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h100, 32'h11111111, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h104, 32'h22222222, 2, 1'b0, 64'h0, 1'b1, 32'h20,
                          64'h22222222_11111111, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 64'h100, 32'h0, 1, 1'b0, 64'hAAAA5555_12345678, 1'b1, 32'h20,
                          64'h0, 1'b0, 32'h12345678));
        vecs.push_back(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'hAAAA5555));
        vecs.push_back(mk(1'b0, 1'b1, 64'h100, 32'h0, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'h20,
                          64'h0, 1'b1, 32'hFFFFFFFF));
        vecs.push_back(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'hAAAA5555));
        vecs.push_back(mk(1'b1, 1'b0, 64'h102, 32'hDEADBEEF, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 64'h100, 32'hDEADBEEF, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 64'h100, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h104, 32'h33333333, 1, 1'b1, 64'h0, 1'b1, 32'h20,
                          64'h33333333_12345678, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h33333333));
        vecs.push_back(mk(1'b1, 1'b0, 64'h100, 32'h44444444, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h10C, 32'h55555555, 0, 1'b0, 64'h0, 1'b1, 32'h21,
                          64'h55555555_44444444, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 64'h1_0000_0100, 32'h0, 0, 1'b0, 64'h0BADF00D_CAFEF00D, 1'b1,
                          32'h2000_0020, 64'h0, 1'b0, 32'hCAFEF00D));
        vecs.push_back(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0BADF00D));
`ifndef SNAPSHOT_MEM_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 1'b1, 64'h200, 32'h0, 20, 1'b0, 64'h0BADF00D_76543210, 1'b1, 32'h40,
                          64'h0, 1'b0, 32'h76543210));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_vld", {63'd0, mem_req_vld}, 64'd0);
        chk("rst_mem_en", {62'd0, mem_wr_en, mem_rd_en}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_ack", {63'd0, ack_vld}, 64'd0);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // A request presented while MEM is busy must be ignored.
        drive_req(1'b0, 1'b1, 64'h100, 32'h0);
        #1; req_vld = 1'b1; wr_en = 1'b1; addr = 64'h104; wr_data = 32'h77777777;
        sb.push_back('{err: 1'b0, data: 32'h05060708});
        @(posedge clk); #1;
        req_vld = 1'b0; wr_en = 1'b0;
        mem_ack_vld = 1'b1; mem_rd_data = 64'h01020304_05060708;
        @(posedge clk); #1;
        mem_ack_vld = 1'b0; mem_rd_data = 64'd0;
        apply_vec(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h01020304));

        // soft_rst mid-MEM, colliding with a memory ack: no upstream ack, snapshot kept.
        drive_req(1'b0, 1'b1, 64'h100, 32'h0);
        @(negedge clk);
        chk("srst_pre_mem_req", {63'd0, mem_req_vld}, 64'd1);
        @(posedge clk); #1;
        soft_rst = 1'b1; mem_ack_vld = 1'b1; mem_rd_data = 64'h99999999_99999999;
        @(posedge clk); #1;
        soft_rst = 1'b0; mem_ack_vld = 1'b0; mem_rd_data = 64'd0;
        @(negedge clk);
        chk("srst_mem_req_vld", {63'd0, mem_req_vld}, 64'd0);
        chk("srst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
        chk("srst_mem_addr", {32'd0, mem_addr}, 64'd0);
        apply_vec(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h01020304));

        // Stray memory acks while idle are ignored.
        @(posedge clk); #1;
        mem_ack_vld = 1'b1; mem_rd_data = 64'h88888888_88888888;
        repeat (2) @(posedge clk);
        #1 mem_ack_vld = 1'b0; mem_rd_data = 64'd0;
        apply_vec(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h01020304));

`ifdef SNAPSHOT_MEM_TIMEOUT_EN
        // Timeout: ack with err in the TMO-th MEM cycle, late memory ack ignored.
        drive_req(1'b0, 1'b1, 64'h100, 32'h0);
        for (int c = 1; c < TMO; c++) begin
            @(negedge clk);
            chk("tmo_wait_no_ack", {63'd0, ack_vld}, 64'd0);
            @(posedge clk); #1;
        end
        sb.push_back('{err: 1'b1, data: 32'h0});
        @(negedge clk);
        chk("tmo_ack", {63'd0, ack_vld}, 64'd1);
        @(posedge clk); #1;
        mem_ack_vld = 1'b1; mem_rd_data = 64'h66666666_66666666;
        @(negedge clk);
        chk("tmo_mem_req_drop", {63'd0, mem_req_vld}, 64'd0);
        @(posedge clk); #1;
        mem_ack_vld = 1'b0; mem_rd_data = 64'd0;
        apply_vec(mk(1'b0, 1'b1, 64'h104, 32'h0, 0, 1'b0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h01020304));
`endif

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snapshot_mem_ext.md
SNAPSHOT_MEM_EXT -- requirements
Module: snapshot_mem_ext

Interface
REQ-001 The block SHALL use the following parameters:
- BUS_DATA_WIDTH, default 32, upstream data width.
- BUS_ADDR_WIDTH, default 64, upstream byte-address width.
- MEM_DATA_WIDTH, default 64, memory word width; integer power-of-2 multiple of BUS_DATA_WIDTH.
- MEM_ADDR_WIDTH, default 32, memory word-address width.
- WR_TRIG_LAST, default 1: 1 = highest partition write triggers memory write; 0 = partition 0 triggers.
- TIMEOUT_CYCLES, default 256, memory-access timeout, >=2.

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- soft_rst  in  1  synchronous soft reset.
- req_vld, wr_en, rd_en  in  1 each  upstream request qualifiers.
- addr  in  BUS_ADDR_WIDTH  upstream byte address.
- wr_data  in  BUS_DATA_WIDTH  upstream write data.
- ack_vld, err  out  1 each  upstream response.
- rd_data  out  BUS_DATA_WIDTH  upstream read data.
- mem_req_vld, mem_wr_en, mem_rd_en  out  1 each  memory request.
- mem_addr  out  MEM_ADDR_WIDTH  memory word address.
- mem_wr_data  out  MEM_DATA_WIDTH  memory write data.
- mem_ack_vld, mem_err  in  1 each  memory response.
- mem_rd_data  in  MEM_DATA_WIDTH  memory read data.

Function
REQ-003 Derived constants SHALL be:
- P = MEM_DATA_WIDTH/BUS_DATA_WIDTH.
- RSV = log2(MEM_DATA_WIDTH/8).
- BSV = log2(BUS_DATA_WIDTH/8).
- Partition index k = addr[RSV-1:BSV].
- Trigger partition T = (WR_TRIG_LAST ? P-1 : 0).
REQ-004 The state machine SHALL be one-hot with states IDLE, MEM and RSP; requests SHALL be sampled only in IDLE and ignored in other states.
REQ-005 An IDLE request with nonzero addr[BSV-1:0], or with wr_en==rd_en, SHALL be a protocol error: go to RSP, then ack_vld=1 and err=1 for one cycle; no memory or snapshot side effects.
REQ-006 A write to k!=T SHALL update snapshot partition k with wr_data, go to RSP, and ack with err=0 one cycle later.
REQ-007 A write to k==T SHALL, in the request cycle:
- update snapshot partition T with wr_data;
- go to MEM;
- next cycle drive mem_req_vld=1, mem_wr_en=1, mem_addr=addr[RSV+MEM_ADDR_WIDTH-1:RSV], mem_wr_data = full snapshot register including the new partition T.
REQ-008 A read to k==0 SHALL go to MEM with mem_rd_en=1. A read to k!=0 SHALL go to RSP and return snapshot partition k with ack_vld=1 one cycle after the request.
REQ-009 In MEM, mem_req_vld, mem_wr_en/mem_rd_en, mem_addr and mem_wr_data SHALL be held stable until mem_ack_vld is sampled high; mem_wr_data SHALL be 0 outside MEM.
REQ-010 In the MEM cycle with mem_ack_vld=1, the block SHALL:
- drive ack_vld=1, err=mem_err and rd_data=mem_rd_data[BUS_DATA_WIDTH-1:0] (rd_data 0 for writes), combinationally;
- drop all mem_* request outputs at the next edge and return to IDLE.
REQ-011 A read ack with mem_err=0 SHALL load all P partitions of the snapshot register from mem_rd_data. A read ack with mem_err=1 SHALL leave the snapshot register unchanged.
REQ-012 ack_vld, err and rd_data SHALL be 0 in every cycle not named in REQ-005 to REQ-010.
REQ-013 mem_ack_vld sampled outside MEM SHALL be ignored.
REQ-014 For P==1, partition 0 SHALL be the trigger for both reads and writes, and RSP SHALL be reached only via REQ-005.

Reset
REQ-015 rst_n low SHALL asynchronously set:
- state = IDLE;
- the snapshot register, mem_req_vld, mem_wr_en, mem_rd_en and mem_addr = 0;
- the timeout counter = 0.
REQ-016 soft_rst high SHALL synchronously produce the same values as REQ-015 except the snapshot register, which SHALL retain its value. An in-flight access SHALL be abandoned with no upstream ack. soft_rst SHALL take priority over all other events in that cycle.

Configuration
REQ-017 With SNAPSHOT_MEM_TIMEOUT_EN defined:
- a counter SHALL increment each MEM cycle without mem_ack_vld;
- when it reaches TIMEOUT_CYCLES-1 without ack, the block SHALL drive ack_vld=1, err=1, rd_data=0 that cycle, drop mem_* request outputs at the next edge, return to IDLE and clear the counter.
Without the macro, no counter SHALL exist and MEM SHALL wait indefinitely.

Verification
Defaults BUS=32, MEM=64, P=2, WR_TRIG_LAST=1.
REQ-018 Write 0x11111111 @0x100, then write 0x22222222 @0x104 -> first acked after 1 cycle with no memory access; second produces mem_wr_en, mem_addr=0x20, mem_wr_data=0x22222222_11111111; ack on mem_ack_vld.
REQ-019 Read @0x100, memory returns 0xAAAA5555_12345678 -> rd_data=0x12345678; a following read @0x104 acks after 1 cycle with rd_data=0xAAAA5555.
REQ-020 Read @0x100 with mem_err=1 and data 0xFFFFFFFF_FFFFFFFF -> err=1; a following read @0x104 still returns the previous snapshot value.
REQ-021 Write @0x102, then a request with wr_en=rd_en=1 -> each acks after 1 cycle with err=1; mem_req_vld stays 0 throughout.
REQ-022 With SNAPSHOT_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, read @0x100 with no memory ack -> ack_vld=1, err=1 in the 8th MEM cycle; a late mem_ack_vld afterwards is ignored.
REQ-023 soft_rst asserted mid-MEM -> mem_req_vld=0 next cycle, no ack; a subsequent read @0x104 returns the snapshot value held before soft_rst.
